hwpe_stream_tcdm_load_streamer_sidech: RTL and testbench

Read-request generator and response collector that sits directly upstream of `hwpe_stream_tcdm_fifo_load_sidech`. It drives that FIFO's TCDM slave port with a strided sequence of word reads, tags each request through the FIFO's side channel, and turns the ordered responses into an HWPE stream with last/tag markers. An outstanding-request credit counter bounds in-flight reads.

---
 rtl/hwpe_stream_tcdm_load_streamer_sidech_if.sv | 28 ++
 rtl/hwpe_stream_tcdm_load_streamer_sidech.sv | 150 +++++++++++++++
 tb/tb_hwpe_stream_tcdm_load_streamer_sidech.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hwpe_stream_tcdm_load_streamer_sidech_if.sv
// TCDM request/response bus and HWPE stream interfaces used by the load streamer.
interface hwpe_stream_intf_tcdm #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  req;
  logic                  gnt;
  logic [ADDR_WIDTH-1:0] add;
  logic                  wen;
  logic [3:0]            be;
  logic [31:0]           data;
  logic [31:0]           r_data;
  logic                  r_valid;

  modport master (output req, add, wen, be, data, input gnt, r_data, r_valid);
  modport slave  (input req, add, wen, be, data, output gnt, r_data, r_valid);
endinterface

interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;

  modport source (output valid, data, strb, input ready);
  modport sink   (input valid, data, strb, output ready);
endinterface

// File: rtl/hwpe_stream_tcdm_load_streamer_sidech.sv
// Strided TCDM read-request generator with side-channel tagging and an
// outstanding-credit limit; responses are passed through as an HWPE stream.
module hwpe_stream_tcdm_load_streamer_sidech #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned CNT_WIDTH       = 16,
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned SIDECH_WIDTH    = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic                    start_i,
  input  logic [ADDR_WIDTH-1:0]   base_addr_i,
  input  logic [ADDR_WIDTH-1:0]   stride_i,
  input  logic [CNT_WIDTH-1:0]    len_i,
  input  logic [SIDECH_WIDTH-2:0] tag_i,
  output logic                    busy_o,
  output logic                    done_o,
  hwpe_stream_intf_tcdm.master    tcdm,
  output logic [SIDECH_WIDTH-1:0] sidech_o,
  input  logic [SIDECH_WIDTH-1:0] sidech_i,
  output logic                    ready_o,
  hwpe_stream_intf_stream.source  stream,
  output logic                    last_o,
  output logic [SIDECH_WIDTH-2:0] tag_o
);

  localparam int unsigned OUT_WIDTH = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]   stride_q, stride_d;
  logic [CNT_WIDTH-1:0]    len_q, len_d;
  logic [SIDECH_WIDTH-2:0] tag_q, tag_d;
  logic [CNT_WIDTH-1:0]    issued_q, issued_d;
  logic [CNT_WIDTH-1:0]    consumed_q, consumed_d;
  logic [OUT_WIDTH-1:0]    outstanding_q, outstanding_d;
  logic                    done_q, done_d;

  logic req;
  logic gnt_fire;
  logic rsp_fire;
  logic last_issue;

  // Request qualification and response passthrough.
  always_comb begin
    req        = (state_q == ISSUE) && (outstanding_q < OUT_WIDTH'(MAX_OUTSTANDING));
    gnt_fire   = req & tcdm.gnt;
    rsp_fire   = tcdm.r_valid & stream.ready;
    last_issue = (issued_q == (len_q - CNT_WIDTH'(1)));
  end

  assign tcdm.req     = req;
  assign tcdm.add     = addr_q;
  assign tcdm.wen     = 1'b1;
  assign tcdm.be      = '1;
  assign tcdm.data    = '0;
  assign sidech_o     = {tag_q, last_issue};

  assign stream.valid = tcdm.r_valid;
  assign stream.data  = tcdm.r_data;
  assign stream.strb  = '1;
  assign ready_o      = stream.ready;
  assign last_o       = sidech_i[0];
  assign tag_o        = sidech_i[SIDECH_WIDTH-1:1];

  assign busy_o       = (state_q != IDLE);
  assign done_o       = done_q;

  // Next-state, address/counter updates and completion pulse.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    stride_d      = stride_q;
    len_d         = len_q;
    tag_d         = tag_q;
    issued_d      = issued_q;
    consumed_d    = consumed_q;
    outstanding_d = outstanding_q;
    done_d        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          addr_d        = base_addr_i;
          stride_d      = stride_i;
          len_d         = len_i;
          tag_d         = tag_i;
          issued_d      = '0;
          consumed_d    = '0;
          outstanding_d = '0;
          state_d       = (len_i == '0) ? DRAIN : ISSUE;
        end
      end
      ISSUE: begin
        if (gnt_fire) begin
          addr_d   = addr_q + stride_q;
          issued_d = issued_q + CNT_WIDTH'(1);
          if (last_issue) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((consumed_q + CNT_WIDTH'(rsp_fire)) == len_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Credit bookkeeping runs in ISSUE and DRAIN alike; a grant and a
    // consume in the same cycle cancel out.
    if (state_q != IDLE) begin
      if (rsp_fire) consumed_d = consumed_q + CNT_WIDTH'(1);
      case ({gnt_fire, rsp_fire && (outstanding_q != '0)})
        2'b10:   outstanding_d = outstanding_q + OUT_WIDTH'(1);
        2'b01:   outstanding_d = outstanding_q - OUT_WIDTH'(1);
        default: outstanding_d = outstanding_q;
      endcase
    end
  end

  // State and datapath registers with synchronous reset / soft clear.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      stride_q      <= '0;
      len_q         <= '0;
      tag_q         <= '0;
      issued_q      <= '0;
      consumed_q    <= '0;
      outstanding_q <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      stride_q      <= stride_d;
      len_q         <= len_d;
      tag_q         <= tag_d;
      issued_q      <= issued_d;
      consumed_q    <= consumed_d;
      outstanding_q <= outstanding_d;
      done_q        <= done_d;
    end
  end

endmodule

// File: tb/tb_hwpe_stream_tcdm_load_streamer_sidech.sv
// Self-checking bench: TCDM memory + side-channel FIFO model, transfer-level
// reference of expected addresses/words, directed and randomized transfers.
module tb_hwpe_stream_tcdm_load_streamer_sidech;

  localparam int MO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, clear = 1'b0, start = 1'b0;
  logic [31:0] base = '0, stride = '0;
  logic [15:0] len = '0;
  logic [2:0]  tag = '0;
  logic        busy, done, rdy_o, last;
  logic [3:0]  sc_o, sc_i;
  logic [2:0]  tag_o;

  hwpe_stream_intf_tcdm   #(.ADDR_WIDTH(32)) tcdm_if ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) str_if ();

  hwpe_stream_tcdm_load_streamer_sidech #(
    .ADDR_WIDTH(32), .CNT_WIDTH(16), .MAX_OUTSTANDING(MO), .SIDECH_WIDTH(4)
  ) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .start_i(start),
    .base_addr_i(base), .stride_i(stride), .len_i(len), .tag_i(tag),
    .busy_o(busy), .done_o(done), .tcdm(tcdm_if), .sidech_o(sc_o),
    .sidech_i(sc_i), .ready_o(rdy_o), .stream(str_if), .last_o(last), .tag_o(tag_o)
  );

  // Handshake control: held levels or per-cycle random.
  bit gnt_hold = 1'b0, gnt_rand = 1'b0, gnt_rnd = 1'b0;
  bit rdy_hold = 1'b0, rdy_rand = 1'b0, rdy_rnd = 1'b0;
  assign tcdm_if.gnt  = gnt_rand ? gnt_rnd : gnt_hold;
  assign str_if.ready = rdy_rand ? rdy_rnd : rdy_hold;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hC3A5_0F1E;
  endfunction

  typedef struct { logic [31:0] addr; logic [3:0] sc; } ent_t;
  ent_t        pend[$];
  logic [31:0] glog_addr[$];
  logic [3:0]  glog_sc[$];
  int          glog_edge[$];
  logic [31:0] olog_data[$];
  logic        olog_last[$];
  logic [2:0]  olog_tag[$];

  int cyc = 0, done_cnt = 0, done_edge = 0, rsp_edge = 0;
  int out_cnt = 0, out_max = 0, bus_viol = 0, drop_viol = 0, done_busy_viol = 0;

  // Values as seen just before each rising edge.
  logic        s_gf = 0, s_rf = 0, s_clr = 1, s_done = 0, s_busy = 0, s_req = 0, s_ng = 0;
  logic [31:0] s_add = 0, s_data = 0;
  logic [3:0]  s_sc = 0;
  logic        s_last = 0;
  logic [2:0]  s_tag = 0;
  logic        p_ng = 0, p_clr = 1;
  logic [31:0] p_add = 0;
  logic [3:0]  p_sc = 0;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    s_gf   <= tcdm_if.req & tcdm_if.gnt;
    s_ng   <= tcdm_if.req & ~tcdm_if.gnt;
    s_req  <= tcdm_if.req;
    s_add  <= tcdm_if.add;
    s_sc   <= sc_o;
    s_rf   <= str_if.valid & rdy_o;
    s_data <= str_if.data;
    s_last <= last;
    s_tag  <= tag_o;
    s_clr  <= rst | clear;
    s_done <= done;
    s_busy <= busy;
  end

  // Memory + downstream FIFO model and protocol monitor, updated mid-cycle.
  always @(negedge clk) begin
    if (s_clr) begin
      pend.delete();
      out_cnt = 0;
    end else begin
      if (s_rf && pend.size() > 0) begin
        void'(pend.pop_front());
        olog_data.push_back(s_data);
        olog_last.push_back(s_last);
        olog_tag.push_back(s_tag);
        rsp_edge = cyc;
        out_cnt--;
      end
      if (s_gf) begin
        pend.push_back('{s_add, s_sc});
        glog_addr.push_back(s_add);
        glog_sc.push_back(s_sc);
        glog_edge.push_back(cyc);
        out_cnt++;
      end
      if (out_cnt > out_max) out_max = out_cnt;
    end
    if (s_done) begin
      done_cnt++;
      done_edge = cyc;
      if (s_busy) done_busy_viol++;
    end
    if (p_ng && !p_clr && !s_clr) begin
      if (!s_req) drop_viol++;
      if (s_add !== p_add || s_sc !== p_sc) bus_viol++;
    end
    p_ng = s_ng; p_clr = s_clr; p_add = s_add; p_sc = s_sc;
    if (pend.size() > 0) begin
      tcdm_if.r_valid = 1'b1;
      tcdm_if.r_data  = mem(pend[0].addr);
      sc_i            = pend[0].sc;
    end else begin
      tcdm_if.r_valid = 1'b0;
      tcdm_if.r_data  = '0;
      sc_i            = '0;
    end
    gnt_rnd = 1'($urandom_range(0, 1));
    rdy_rnd = 1'($urandom_range(0, 1));
  end

  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic clear_logs();
    glog_addr.delete(); glog_sc.delete(); glog_edge.delete();
    olog_data.delete(); olog_last.delete(); olog_tag.delete();
    done_cnt = 0; out_max = 0;
  endtask

  task automatic kick(input logic [31:0] b, input logic [31:0] s, input logic [15:0] l,
                      input logic [2:0] t);
    step();
    base = b; stride = s; len = l; tag = t; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      step();
      n++;
    end
    chk("done_within_budget", done_cnt != 0, 1);
    repeat (3) step();
  endtask

  // Reference: word i of a transfer reads base + i*stride (mod 2^32), is last
  // only at i == len-1, and carries the transfer tag.
  task automatic check_xfer(input string nm, input logic [31:0] b, input logic [31:0] s,
                            input logic [15:0] l, input logic [2:0] t, input bit consec);
    logic [31:0] ea;
    chk({nm, "_grants"}, glog_addr.size(), l);
    chk({nm, "_words"}, olog_data.size(), l);
    for (int i = 0; i < int'(l); i++) begin
      ea = b + s * 32'(i);
      if (i < glog_addr.size()) begin
        chk({nm, "_addr"}, glog_addr[i], ea);
        chk({nm, "_sidech_o"}, glog_sc[i], {t, i == int'(l) - 1});
        if (consec) chk({nm, "_consec"}, glog_edge[i], glog_edge[0] + i);
      end
      if (i < olog_data.size()) begin
        chk({nm, "_data"}, olog_data[i], mem(ea));
        chk({nm, "_last"}, olog_last[i], i == int'(l) - 1);
        chk({nm, "_tag"}, olog_tag[i], t);
      end
    end
    chk({nm, "_done_count"}, done_cnt, 1);
    if (l != 0) chk({nm, "_done_timing"}, done_edge, rsp_edge + 1);
    chk({nm, "_busy_after"}, busy, 0);
    chk({nm, "_credit_bound"}, out_max <= MO, 1);
    chk({nm, "_bus_stable"}, bus_viol, 0);
    chk({nm, "_req_hold"}, drop_viol, 0);
    chk({nm, "_done_busy"}, done_busy_viol, 0);
  endtask

  initial begin
    logic [31:0] a_hold, rb, rs;
    logic [3:0]  sc_hold;
    logic [15:0] rl;
    logic [2:0]  rt;
    int n;

    // Reset state
    rst = 1'b1;
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_req", tcdm_if.req, 0);
    chk("rst_add", tcdm_if.add, 0);
    chk("rst_sidech_o", sc_o, 0);
    chk("rst_wen", tcdm_if.wen, 1);
    chk("rst_be", tcdm_if.be, 4'hF);
    chk("rst_wdata", tcdm_if.data, 0);
    chk("rst_strb", str_if.strb, 4'hF);
    rst = 1'b0;
    step();
    chk("post_rst_req", tcdm_if.req, 0);

    // Basic strided read
    gnt_hold = 1'b1; rdy_hold = 1'b1;
    clear_logs();
    kick(32'h1000, 32'd4, 16'd4, 3'd0);
    chk("basic_busy_t1", busy, 1);
    chk("basic_req_t1", tcdm_if.req, 1);
    chk("basic_add_t1", tcdm_if.add, 32'h1000);
    wait_done(200);
    check_xfer("basic", 32'h1000, 32'd4, 16'd4, 3'd0, 1'b1);

    // Credit limit
    rdy_hold = 1'b0;
    clear_logs();
    kick(32'h2000, 32'd4, 16'd20, 3'd3);
    repeat (30) step();
    chk("credit_grants", glog_addr.size(), MO);
    chk("credit_req_low", tcdm_if.req, 0);
    chk("credit_ready_o", rdy_o, 0);
    rdy_hold = 1'b1;
    wait_done(300);
    check_xfer("credit", 32'h2000, 32'd4, 16'd20, 3'd3, 1'b0);
    chk("credit_max", out_max, MO);

    // Address wrap and tag
    clear_logs();
    kick(32'hFFFF_FFF8, 32'd8, 16'd3, 3'd5);
    wait_done(200);
    check_xfer("wrap", 32'hFFFF_FFF8, 32'd8, 16'd3, 3'd5, 1'b1);

    // Grant stall on the second request
    clear_logs();
    kick(32'h3000, 32'd4, 16'd4, 3'd2);
    step();
    gnt_hold = 1'b0;
    a_hold = tcdm_if.add; sc_hold = sc_o;
    chk("stall_add_second", a_hold, 32'h3004);
    repeat (3) begin
      step();
      chk("stall_add", tcdm_if.add, a_hold);
      chk("stall_sidech", sc_o, sc_hold);
      chk("stall_req", tcdm_if.req, 1);
      chk("stall_grants", glog_addr.size(), 1);
    end
    gnt_hold = 1'b1;
    wait_done(200);
    check_xfer("stall", 32'h3000, 32'd4, 16'd4, 3'd2, 1'b0);

    // len = 0
    clear_logs();
    step();
    base = 32'h7000; stride = 32'd4; len = 16'd0; tag = 3'd1; start = 1'b1;
    step();
    start = 1'b0;
    chk("len0_busy_t1", busy, 1);
    chk("len0_req_t1", tcdm_if.req, 0);
    chk("len0_done_t1", done, 0);
    step();
    chk("len0_done_t2", done, 1);
    chk("len0_busy_t2", busy, 0);
    step();
    chk("len0_done_t3", done, 0);
    chk("len0_grants", glog_addr.size(), 0);
    chk("len0_done_count", done_cnt, 1);

    // Start while busy is ignored
    clear_logs();
    kick(32'h4000, 32'd12, 16'd6, 3'd1);
    step();
    base = 32'h9990; stride = 32'd64; len = 16'd2; tag = 3'd6; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(200);
    check_xfer("restart", 32'h4000, 32'd12, 16'd6, 3'd1, 1'b0);

    // Mid-transfer clear with three requests outstanding
    rdy_hold = 1'b0;
    clear_logs();
    kick(32'h5000, 32'd4, 16'd10, 3'd4);
    n = 0;
    while (glog_addr.size() < 3 && n < 20) begin
      step();
      n++;
    end
    chk("clr_pre_grants", glog_addr.size(), 3);
    chk("clr_pre_busy", busy, 1);
    gnt_hold = 1'b0; clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_req", tcdm_if.req, 0);
    chk("clr_busy", busy, 0);
    chk("clr_done", done, 0);
    chk("clr_sidech_o", sc_o, 0);
    repeat (4) step();
    chk("clr_no_done", done_cnt, 0);
    chk("clr_grants_after", glog_addr.size(), 3);
    gnt_hold = 1'b1; rdy_hold = 1'b1;
    clear_logs();
    kick(32'h6000, 32'd4, 16'd5, 3'd7);
    wait_done(200);
    check_xfer("after_clr", 32'h6000, 32'd4, 16'd5, 3'd7, 1'b1);

    // Randomized transfers with random grant / ready
    gnt_rand = 1'b1; rdy_rand = 1'b1;
    for (int k = 0; k < 5; k++) begin
      rb = $urandom;
      rs = (k == 0) ? 32'hFFFF_FFFC : ($urandom_range(0, 64) << 2);
      rl = 16'($urandom_range(1, 24));
      rt = 3'($urandom_range(0, 7));
      clear_logs();
      kick(rb, rs, rl, rt);
      wait_done(1000);
      check_xfer("rand", rb, rs, rl, rt, 1'b0);
    end
    gnt_rand = 1'b0; rdy_rand = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
